led_matrix_scanner: RTL and testbench

Parametrised row-multiplexed LED matrix driver, replacing the fixed 5x5 line/column PIO export pair with a self-scanning block. Holds a double-buffered frame: a host loads the back buffer row by row and requests a swap; the swap happens only at a frame boundary, so no tearing. Adds global PWM brightness and selectable output polarity. Sits between the CPU-side register interface and the m_led_linha / m_led_coluna pins.

---
 rtl/led_matrix_scanner.sv | 130 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered frame, global PWM
// brightness and selectable row/column drive polarity.
module led_matrix_scanner #(
  parameter int unsigned ROWS         = 5,
  parameter int unsigned COLS         = 5,
  parameter int unsigned SUB          = 2500,
  parameter int unsigned BW           = 3,
  parameter bit          ROW_ACT_HIGH = 1'b1,
  parameter bit          COL_ACT_HIGH = 1'b0,
  localparam int unsigned RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  input  logic [BW-1:0]   brightness,
  output logic            swap_ack,
  output logic            frame_tick,
  output logic [ROWS-1:0] m_led_linha,
  output logic [COLS-1:0] m_led_coluna
);

  localparam int unsigned SW = (SUB > 1) ? $clog2(SUB) : 1;
  localparam logic [ROWS-1:0] ROW_IDLE = ROW_ACT_HIGH ? '0 : '1;
  localparam logic [COLS-1:0] COL_IDLE = COL_ACT_HIGH ? '0 : '1;

  logic [SW-1:0]   sub_q, sub_d;
  logic [BW-1:0]   phase_q, phase_d;
  logic [RW-1:0]   row_q, row_d;
  logic            pend_q, pend_d;
  logic            swap_ack_q, swap_ack_d;
  logic            frame_tick_q, frame_tick_d;
  logic [ROWS-1:0] linha_q, linha_d;
  logic [COLS-1:0] coluna_q, coluna_d;
  logic [COLS-1:0] back_q  [ROWS];
  logic [COLS-1:0] back_d  [ROWS];
  logic [COLS-1:0] front_q [ROWS];
  logic [COLS-1:0] front_d [ROWS];

  logic            sub_wrap, phase_wrap, row_last, frame_wrap, swap_exec;
  logic [ROWS-1:0] row_onehot;
  logic [COLS-1:0] row_pattern;

  always_comb begin
    sub_wrap    = (sub_q == SW'(SUB - 1));
    phase_wrap  = (phase_q == '1);
    row_last    = (row_q == RW'(ROWS - 1));
    frame_wrap  = enable && row_last && phase_wrap && sub_wrap;
    swap_exec   = pend_q && (frame_wrap || !enable);
    row_onehot  = ROWS'(1) << row_q;
    row_pattern = front_q[row_q];

    sub_d        = sub_q;
    phase_d      = phase_q;
    row_d        = row_q;
    linha_d      = ROW_IDLE;
    coluna_d     = COL_IDLE;
    back_d       = back_q;
    front_d      = front_q;
    pend_d       = pend_q | swap_req;
    swap_ack_d   = 1'b0;
    frame_tick_d = frame_wrap;

    if (!enable) begin
      sub_d   = '0;
      phase_d = '0;
      row_d   = '0;
    end else begin
      if (sub_wrap) begin
        sub_d = '0;
        if (phase_wrap) begin
          phase_d = '0;
          row_d   = row_last ? '0 : row_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        sub_d = sub_q + 1'b1;
      end
      linha_d = ROW_ACT_HIGH ? row_onehot : ~row_onehot;
      if (phase_q <= brightness)
        coluna_d = COL_ACT_HIGH ? row_pattern : ~row_pattern;
    end

    if (wr_en && (32'(wr_row) < ROWS))
      back_d[wr_row] = wr_data;

    // Front takes the pre-edge back contents; a same-cycle request is absorbed.
    if (swap_exec) begin
      front_d    = back_q;
      pend_d     = 1'b0;
      swap_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sub_q        <= '0;
      phase_q      <= '0;
      row_q        <= '0;
      pend_q       <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      linha_q      <= ROW_IDLE;
      coluna_q     <= COL_IDLE;
      back_q       <= '{default: '0};
      front_q      <= '{default: '0};
    end else begin
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      pend_q       <= pend_d;
      swap_ack_q   <= swap_ack_d;
      frame_tick_q <= frame_tick_d;
      linha_q      <= linha_d;
      coluna_q     <= coluna_d;
      back_q       <= back_d;
      front_q      <= front_d;
    end
  end

  assign swap_ack     = swap_ack_q;
  assign frame_tick   = frame_tick_q;
  assign m_led_linha  = linha_q;
  assign m_led_coluna = coluna_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner at 5x5, SUB=2, BW=3 (16-cycle row slot, 80-cycle frame).
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, wr_en, swap_req;
  logic [2:0] wr_row;
  logic [4:0] wr_data;
  logic [2:0] brightness;
  logic       swap_ack, frame_tick;
  logic [4:0] linha, coluna;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cnt, acks, ticks;

  led_matrix_scanner #(
    .ROWS(5), .COLS(5), .SUB(2), .BW(3), .ROW_ACT_HIGH(1'b1), .COL_ACT_HIGH(1'b0)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .enable       (enable),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .brightness   (brightness),
    .swap_ack     (swap_ack),
    .frame_tick   (frame_tick),
    .m_led_linha  (linha),
    .m_led_coluna (coluna)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    swap_req = 1'b0; brightness = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_linha", linha, 5'b00000);
    chk("rst_coluna", coluna, 5'b11111);
    chk("rst_ack", swap_ack, 1'b0);
    chk("rst_tick", frame_tick, 1'b0);

    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; cyc = 0;
    step();
    chk("row0_start", linha, 5'b00001);
    chk("row0_col", coluna, 5'b11111);

    run_to(9);
    wr_en = 1'b1; wr_row = 3'd2; wr_data = 5'b10101;
    step();
    wr_en = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(16); chk("row0_end", linha, 5'b00001);
    run_to(17); chk("row1_start", linha, 5'b00010);
    run_to(40); chk("row2_f0_linha", linha, 5'b00100);
    chk("row2_f0_noswap", coluna, 5'b11111);
    run_to(79);
    chk("pre_wrap_tick", frame_tick, 1'b0);
    chk("pre_wrap_ack", swap_ack, 1'b0);
    chk("row4_linha", linha, 5'b10000);
    run_to(80);
    chk("wrap_tick", frame_tick, 1'b1);
    chk("wrap_ack", swap_ack, 1'b1);
    run_to(81);
    chk("post_wrap_tick", frame_tick, 1'b0);
    chk("post_wrap_ack", swap_ack, 1'b0);
    chk("f1_row0", linha, 5'b00001);
    run_to(113);
    chk("f1_row2_linha", linha, 5'b00100);
    chk("f1_row2_col", coluna, 5'b01010);
    run_to(128); chk("f1_row2_col_end", coluna, 5'b01010);
    run_to(129);
    chk("f1_row3_linha", linha, 5'b01000);
    chk("f1_row3_col", coluna, 5'b11111);

    brightness = 3'd0;
    run_to(192);
    cnt = 0;
    repeat (16) begin step(); if (coluna !== 5'b11111) cnt++; end
    chk("duty_b0", cnt, 2);
    brightness = 3'd3;
    run_to(272);
    cnt = 0;
    repeat (16) begin step(); if (coluna !== 5'b11111) cnt++; end
    chk("duty_b3", cnt, 8);
    brightness = 3'd7;
    run_to(352);
    cnt = 0;
    repeat (16) begin step(); if (coluna !== 5'b11111) cnt++; end
    chk("duty_b7", cnt, 16);

    run_to(400);
    acks = 0; ticks = 0;
    while (cyc < 480) begin
      case (cyc)
        403: swap_req = 1'b1;
        404: swap_req = 1'b0;
        410: begin wr_en = 1'b1; wr_row = 3'd7; wr_data = 5'b11111; end
        411: begin wr_row = 3'd0; wr_data = 5'b00011; end
        412: wr_en = 1'b0;
        420: swap_req = 1'b1;
        421: swap_req = 1'b0;
        default: ;
      endcase
      step();
      if (swap_ack) acks++;
      if (frame_tick) ticks++;
    end
    chk("merge_acks", acks, 1);
    chk("merge_ticks", ticks, 1);
    chk("merge_ack_at_wrap", swap_ack, 1'b1);
    run_to(481); chk("f6_row0_col", coluna, 5'b11100);
    run_to(497); chk("f6_row1_col", coluna, 5'b11111);
    run_to(513); chk("f6_row2_col", coluna, 5'b01010);
    run_to(529); chk("f6_row3_col", coluna, 5'b11111);
    run_to(545); chk("f6_row4_col", coluna, 5'b11111);

    run_to(598);
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 5'b11000;
    step();
    wr_en = 1'b0;
    run_to(600);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(612);
    chk("pre_dis_linha", linha, 5'b01000);
    chk("pre_dis_col", coluna, 5'b11111);
    enable = 1'b0;
    step();
    chk("dis_linha", linha, 5'b00000);
    chk("dis_col", coluna, 5'b11111);
    chk("dis_ack", swap_ack, 1'b1);
    chk("dis_tick", frame_tick, 1'b0);
    step();
    chk("dis_ack_clear", swap_ack, 1'b0);
    repeat (2) step();
    chk("dis_hold_linha", linha, 5'b00000);
    chk("dis_hold_tick", frame_tick, 1'b0);
    enable = 1'b1; cyc = 0;
    step();
    chk("reen_row0", linha, 5'b00001);
    chk("reen_col0", coluna, 5'b11100);
    run_to(49);
    chk("reen_row3", linha, 5'b01000);
    chk("reen_col3", coluna, 5'b00111);

    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_linha", linha, 5'b00000);
    chk("async_col", coluna, 5'b11111);
    chk("async_ack", swap_ack, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_linha", linha, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0;
    acks = 0;
    repeat (3) begin step(); if (swap_ack) acks++; end
    chk("no_stale_swap", acks, 0);
    chk("post_rst_dis_linha", linha, 5'b00000);
    enable = 1'b1; cyc = 0;
    step();
    chk("post_rst_row0", linha, 5'b00001);
    chk("post_rst_col0", coluna, 5'b11111);
    run_to(49); chk("post_rst_col3", coluna, 5'b11111);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(80); chk("post_rst_swap_ack", swap_ack, 1'b1);
    run_to(113); chk("post_rst_back_zero", coluna, 5'b11111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
